// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: end-of-count modes and control states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_SAT  = 2'b01,
        ST_DONE = 2'b10
    } cnt_state_e;

endpackage

// File: rtl/counter_updown_mod.sv
// Up/down counter with runtime inclusive limit, synchronous load and
// wrap / saturate / one-shot end-of-count behaviour.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             tc,
    output logic             done
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             at_bound;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    // Boundary is checked before stepping, so the step itself never overflows.
    assign at_bound = up_dn ? (result_q >= limit) : (result_q == '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (load) begin
            result_d = load_val;
            state_d  = ST_RUN;
            done_d   = 1'b0;
        end else if (ena && state_q != ST_DONE) begin
            if (!at_bound) begin
                result_d = up_dn ? result_q + WIDTH'(1) : result_q - WIDTH'(1);
                state_d  = ST_RUN;
            end else begin
                case (mode_sel)
                    MODE_SAT: begin
                        // Pulse only on entry; sitting in saturation is silent.
                        tc_d    = (state_q != ST_SAT);
                        state_d = ST_SAT;
                    end
                    MODE_ONESHOT: begin
                        tc_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                    default: begin
                        result_d = up_dn ? '0 : limit;
                        tc_d     = 1'b1;
                        state_d  = ST_RUN;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            result_q <= RESET_VAL;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign tc     = tc_q;
    assign done   = done_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: each vector has hand-computed expectations.
module tb_counter_updown_mod;

    logic       clk;
    logic       reset;
    logic       ena;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic       up_dn;
    logic [1:0] mode;
    logic [7:0] result;
    logic       tc;
    logic       done;

    int tests_run;
    int tests_failed;

    counter_updown_mod #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .up_dn    (up_dn),
        .mode     (mode),
        .result   (result),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] r, input logic t, input logic d);
        check_val({tag, ".result"}, {24'd0, result}, {24'd0, r});
        check_val({tag, ".tc"}, {31'd0, tc}, {31'd0, t});
        check_val({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b1; ena = 1'b0; load = 1'b0; load_val = 8'd0;
        limit = 8'd9; up_dn = 1'b1; mode = 2'b00;
        #12;
        expect_out("reset", 8'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // 1: WRAP up, limit 9
        do_load(8'd7);
        expect_out("t1.load", 8'd7, 1'b0, 1'b0);
        ena = 1'b1;
        tick(); expect_out("t1.s1", 8'd8, 1'b0, 1'b0);
        tick(); expect_out("t1.s2", 8'd9, 1'b0, 1'b0);
        tick(); expect_out("t1.wrap", 8'd0, 1'b1, 1'b0);
        ena = 1'b0;
        tick(); expect_out("t1.hold", 8'd0, 1'b0, 1'b0);

        // 2: WRAP down, limit 9
        up_dn = 1'b0;
        do_load(8'd1);
        ena = 1'b1;
        tick(); expect_out("t2.s1", 8'd0, 1'b0, 1'b0);
        tick(); expect_out("t2.wrap", 8'd9, 1'b1, 1'b0);
        ena = 1'b0;

        // 3: SAT up, limit 200
        mode = 2'b01; limit = 8'd200; up_dn = 1'b1;
        do_load(8'd198);
        ena = 1'b1;
        tick(); expect_out("t3.s1", 8'd199, 1'b0, 1'b0);
        tick(); expect_out("t3.s2", 8'd200, 1'b0, 1'b0);
        tick(); expect_out("t3.sat", 8'd200, 1'b1, 1'b0);
        tick(); expect_out("t3.insat", 8'd200, 1'b0, 1'b0);
        up_dn = 1'b0;
        tick(); expect_out("t3.rev", 8'd199, 1'b0, 1'b0);
        ena = 1'b0;

        // 4: ONESHOT down
        mode = 2'b10;
        do_load(8'd3);
        ena = 1'b1;
        tick(); expect_out("t4.s1", 8'd2, 1'b0, 1'b0);
        tick(); expect_out("t4.s2", 8'd1, 1'b0, 1'b0);
        tick(); expect_out("t4.s3", 8'd0, 1'b0, 1'b0);
        tick(); expect_out("t4.done", 8'd0, 1'b1, 1'b1);
        tick(); expect_out("t4.stay", 8'd0, 1'b0, 1'b1);
        mode = 2'b00;
        tick(); expect_out("t4.modechg", 8'd0, 1'b0, 1'b1);
        ena = 1'b0;
        do_load(8'd5);
        expect_out("t4.reload", 8'd5, 1'b0, 1'b0);

        // 5: load over limit, load has priority over ena
        mode = 2'b00; limit = 8'd9; up_dn = 1'b1; ena = 1'b1;
        do_load(8'd250);
        expect_out("t5.load", 8'd250, 1'b0, 1'b0);
        tick(); expect_out("t5.wrap", 8'd0, 1'b1, 1'b0);
        ena = 1'b0;

        // 6: async reset mid-cycle
        limit = 8'd100;
        do_load(8'd35);
        ena = 1'b1;
        tick(); expect_out("t6.s1", 8'd36, 1'b0, 1'b0);
        tick(); expect_out("t6.s2", 8'd37, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 expect_out("t6.async", 8'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        tick(); expect_out("t6.resume", 8'd1, 1'b0, 1'b0);

        // reset out of DONE clears done and tc without a clock edge
        ena = 1'b0; mode = 2'b10; up_dn = 1'b0;
        do_load(8'd0);
        ena = 1'b1;
        tick(); expect_out("t7.done", 8'd0, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1 expect_out("t7.async", 8'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        mode = 2'b00; up_dn = 1'b1; limit = 8'd9;
        tick(); expect_out("t7.resume", 8'd1, 1'b0, 1'b0);

        // limit 0, up, WRAP: stuck at 0 with tc every enabled cycle
        limit = 8'd0; ena = 1'b0;
        do_load(8'd0);
        ena = 1'b1;
        tick(); expect_out("t8.z1", 8'd0, 1'b1, 1'b0);
        tick(); expect_out("t8.z2", 8'd0, 1'b1, 1'b0);
        ena = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down counter with a runtime limit. It is the successor to the fixed down-counter and is used as the general timing/count primitive in lab datapaths. It adds a synchronous load, a direction control and three end-of-count modes: wrap, saturate and one-shot. It also produces a terminal-count pulse and a sticky done flag for controller FSMs.

Parameters:
WIDTH, 8, counter and data width in bits (>=2)
RESET_VAL, 0, value of result after reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
ena  input  1  count enable; one step per enabled cycle
load  input  1  synchronous load of load_val; priority over ena
load_val  input  WIDTH  value loaded when load=1
limit  input  WIDTH  inclusive upper count bound, unsigned
up_dn  input  1  1 = count up, 0 = count down
mode  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (behaves as WRAP)
result  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle
done  output  1  one-shot complete, sticky until load or reset

Behaviour:
- Reset (async, active-high): result=RESET_VAL, tc=0, done=0, state=RUN. Outputs change immediately on reset assertion, not at the next edge.
- State machine: RUN, SAT, DONE. All outputs are registered. result and tc update on the same edge.
- Boundary for the current step:
  - up: result >= limit (unsigned compare)
  - down: result == 0
- Priority per edge: reset > load > enabled step > hold.
- Load: result=load_val, state=RUN, done=0, tc=0. ena and state are ignored. load_val > limit is legal.
- ena=0 (no load): everything holds; tc=0.
- Enabled step, not at boundary: result +/- 1, state=RUN, tc=0. This also leaves SAT, e.g. after up_dn reverses.
- Enabled step at boundary, by mode:
  - WRAP: up wraps to 0, down wraps to limit; tc=1; state=RUN.
  - SAT: result holds; tc=1 only on the RUN->SAT transition; while already in SAT, tc=0.
  - ONESHOT: result holds; state=DONE; done=1; tc=1 for that cycle only.
- DONE: ena ignored, result holds, tc=0. Leaves only on load or reset. A mode change does not release DONE.
- Mode and limit are sampled every enabled cycle. Changes take effect on the next step with no latency.
- limit=0, up, WRAP: result stays 0 and tc=1 on every enabled cycle.
- All arithmetic is modulo 2^WIDTH. Overflow cannot occur because the boundary check precedes the step.
- reset asserted mid-operation, including in DONE or SAT: immediate return to the reset state. Counting resumes on the first enabled edge after deassertion.

Decomposition:
- Package counter_pkg:
  - typedef enum logic [1:0] mode_e {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD}
  - typedef enum logic [1:0] cnt_state_e {ST_RUN, ST_SAT, ST_DONE}
- Single module; no sub-module. Next-count and boundary logic is one always_comb block; state, result, tc and done are one always_ff with async reset.

Test Plan (WIDTH=8, RESET_VAL=0):
1. WRAP up, limit=9: load 7, then ena for 3 cycles -> result 8, 9, 0; tc=1 only in the cycle result=0.
2. WRAP down, limit=9: load 1, ena for 2 cycles -> result 0, then 9 with tc=1.
3. SAT up, limit=200: load 198, ena for 4 cycles -> result 199, 200, 200, 200; tc=1 only on the third edge.
   Then up_dn=0 with ena -> result 199, state RUN, tc=0.
4. ONESHOT down: load 3, ena held -> result 2, 1, 0; next edge done=1, tc=1, result 0.
   Further ena -> no change, tc=0. Then load 5 -> result 5, done=0.
5. Load over limit plus priority: limit=9, WRAP up, load=1 with load_val=250 and ena=1 -> result 250.
   Next enabled edge -> result 0, tc=1. load and ena together always load.
6. Async reset: count reaches 37, assert reset between edges -> result=0, tc=0, done=0 before the next edge.
   Deassert reset, ena=1 -> result 1 on the first edge.
